// File: rtl/byte_bus_if.sv
// Byte-serial memory bus between the CPU handler (master) and a memory target (slave).
interface byte_bus_if;
    logic       frame_sync;
    logic       rw;
    logic [7:0] addr_byte;
    logic [7:0] wdata_byte;
    logic [7:0] rdata_byte;
    logic       rdata_valid;
    logic       busy;
    logic       frame_done;
    logic       range_err;

    modport master (
        output frame_sync, rw, addr_byte, wdata_byte,
        input  rdata_byte, rdata_valid, busy, frame_done, range_err
    );

    modport slave (
        input  frame_sync, rw, addr_byte, wdata_byte,
        output rdata_byte, rdata_valid, busy, frame_done, range_err
    );
endinterface

// File: rtl/byte_bus_target.sv
// Byte-serial bus target: collects a 4-byte address/write word, does one 32-bit
// RAM access, and streams the 32-bit read word back LSB first over four cycles.
module byte_bus_target #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    byte_bus_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, CAP1, CAP2, CAP3, ACCESS, RSP0, RSP1, RSP2, RSP3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        rw_q, rw_d;
    logic [7:0]  rbyte_q, rbyte_d;
    logic        rvalid_q, rvalid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rerr_q, rerr_d;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   rd_word;
    logic          mem_we;
    logic          unused_lo;

    // Word access only: the two byte-offset bits never reach the RAM.
    assign idx       = addr_q[AW+1:2];
    assign in_range  = (addr_q[31:AW+2] == '0);
    assign rd_word   = in_range ? mem[idx] : '0;
    assign unused_lo = ^addr_q[1:0];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        rbyte_d  = '0;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        rerr_d   = rerr_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_sync) begin
                    addr_d  = {bus.addr_byte, addr_q[31:8]};
                    wd_d    = {bus.wdata_byte, wd_q[31:8]};
                    rw_d    = bus.rw;
                    state_d = CAP1;
                end
            end
            CAP1, CAP2, CAP3: begin
                // Bytes arrive LSB first, so shifting in at the top leaves byte 0 at [7:0].
                addr_d  = {bus.addr_byte, addr_q[31:8]};
                wd_d    = {bus.wdata_byte, wd_q[31:8]};
                state_d = (state_q == CAP3) ? ACCESS :
                          (state_q == CAP2) ? CAP3 : CAP2;
            end
            ACCESS: begin
                mem_we   = ~rw_q & in_range;
                rd_d     = rw_q ? rd_word : '0;
                rbyte_d  = rw_q ? rd_word[7:0] : 8'h00;
                rvalid_d = rw_q;
                if (!in_range) rerr_d = 1'b1;
                state_d  = RSP0;
            end
            RSP0: begin
                rbyte_d  = rd_q[15:8];
                rvalid_d = rw_q;
                state_d  = RSP1;
            end
            RSP1: begin
                rbyte_d  = rd_q[23:16];
                rvalid_d = rw_q;
                state_d  = RSP2;
            end
            RSP2: begin
                rbyte_d  = rd_q[31:24];
                rvalid_d = rw_q;
                done_d   = 1'b1;
                state_d  = RSP3;
            end
            RSP3:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wd_q     <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            rbyte_q  <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            rbyte_q  <= rbyte_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rerr_q   <= rerr_d;
        end
    end

    // RAM is never reset; a reset landing on ACCESS abandons the write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[idx] <= wd_q;
    end

    assign bus.rdata_byte  = rbyte_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.range_err   = rerr_q;
endmodule

// File: tb/tb_byte_bus_target.sv
// Directed bench for byte_bus_target: frames driven cycle by cycle, outputs
// recorded per frame cycle and compared against hand-computed values.
module tb_byte_bus_target;
    logic clk;
    logic rst;
    byte_bus_if bus();

    byte_bus_target #(.DEPTH(256), .AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] rb [10];
    logic       rv [10];
    logic       fd [10];
    logic       bz [10];
    logic       re [10];

    task automatic sample(input int k);
        rb[k] = bus.rdata_byte;
        rv[k] = bus.rdata_valid;
        fd[k] = bus.frame_done;
        bz[k] = bus.busy;
        re[k] = bus.range_err;
    endtask

    // Called #1 after a rising edge; that cycle is frame cycle 0. Returns in cycle 9.
    task automatic run_frame(input logic r, input logic [31:0] a, input logic [31:0] w,
                             input int spur);
        bus.frame_sync = 1'b1;
        bus.rw         = r;
        bus.addr_byte  = a[7:0];
        bus.wdata_byte = w[7:0];
        sample(0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            bus.frame_sync = (k == spur);
            bus.rw         = 1'($urandom);
            if (k < 4) begin
                bus.addr_byte  = a[8*k +: 8];
                bus.wdata_byte = w[8*k +: 8];
            end else begin
                bus.addr_byte  = 8'($urandom);
                bus.wdata_byte = 8'($urandom);
            end
            sample(k);
        end
        bus.frame_sync = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.frame_sync = 1'($urandom);
            bus.rw         = 1'($urandom);
            bus.addr_byte  = 8'($urandom);
            bus.wdata_byte = 8'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if ({bus.rdata_byte, bus.rdata_valid, bus.busy, bus.frame_done, bus.range_err} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rbyte=%h rv=%b busy=%b done=%b rerr=%b, want all 0",
                     bus.rdata_byte, bus.rdata_valid, bus.busy, bus.frame_done, bus.range_err);
        end
        bus.frame_sync = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        logic [31:0] e;
        e = 32'hA1B2_C3D4;
        run_frame(1'b0, 32'h0000_0010, e, -1);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (rv[k] !== 1'b0 || fd[k] !== 1'(k == 8) || bz[k] !== 1'(k <= 8)) begin
                errors++;
                $display("FAIL write_frame c%0d: got rv=%b done=%b busy=%b, want rv=0 done=%b busy=%b",
                         k, rv[k], fd[k], bz[k], 1'(k == 8), 1'(k <= 8));
            end
        end
        run_frame(1'b1, 32'h0000_0010, 32'h0, -1);
        for (int k = 4; k <= 9; k++) begin
            checks++;
            if (rv[k] !== 1'(k >= 5 && k <= 8) || (k >= 5 && k <= 8 && rb[k] !== e[8*(k-5) +: 8])) begin
                errors++;
                $display("FAIL read_frame c%0d: got byte=%h rv=%b, want byte=%h rv=%b",
                         k, rb[k], rv[k], (k >= 5 && k <= 8) ? e[8*((k-5)%4) +: 8] : 8'h00,
                         1'(k >= 5 && k <= 8));
            end
        end
        checks++;
        if (re[9] !== 1'b0 || fd[8] !== 1'b1) begin
            errors++;
            $display("FAIL read_flags: got rerr=%b done=%b, want rerr=0 done=1", re[9], fd[8]);
        end
    endtask

    task automatic test_range;
        logic [31:0] e;
        e = 32'hCAFE_0001;
        run_frame(1'b0, 32'h0000_0000, e, -1);
        run_frame(1'b0, 32'h0000_0400, 32'h1234_5678, -1);
        checks++;
        if (re[4] !== 1'b0 || re[5] !== 1'b1 || rv[5] !== 1'b0) begin
            errors++;
            $display("FAIL oob_write_flag: got rerr c4=%b c5=%b rv=%b, want 0 1 0", re[4], re[5], rv[5]);
        end
        run_frame(1'b1, 32'h0000_0000, 32'h0, -1);
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (rb[k] !== e[8*(k-5) +: 8] || rv[k] !== 1'b1 || re[k] !== 1'b1) begin
                errors++;
                $display("FAIL oob_ram0_kept c%0d: got byte=%h rv=%b rerr=%b, want byte=%h rv=1 rerr=1",
                         k, rb[k], rv[k], re[k], e[8*(k-5) +: 8]);
            end
        end
        run_frame(1'b1, 32'h0000_0400, 32'h0, -1);
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (rb[k] !== 8'h00 || rv[k] !== 1'b1) begin
                errors++;
                $display("FAIL oob_read c%0d: got byte=%h rv=%b, want byte=00 rv=1", k, rb[k], rv[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        e = 32'hDEAD_BEEF;
        run_frame(1'b0, 32'h0000_0004, e, -1);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (bz[k] !== 1'(k <= 8)) begin
                errors++;
                $display("FAIL b2b_busy1 c%0d: got %b, want %b", k, bz[k], 1'(k <= 8));
            end
        end
        run_frame(1'b1, 32'h0000_0004, 32'h0, -1);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (bz[k] !== 1'b1 || (k >= 5 && (rb[k] !== e[8*((k-5)%4) +: 8] || rv[k] !== 1'b1))) begin
                errors++;
                $display("FAIL b2b_read c%0d: got busy=%b byte=%h rv=%b, want busy=1 byte=%h rv=%b",
                         k, bz[k], rb[k], rv[k], (k >= 5) ? e[8*((k-5)%4) +: 8] : rb[k], 1'(k >= 5));
            end
        end
    endtask

    task automatic test_spurious;
        logic [31:0] e;
        e = 32'hA1B2_C3D4;
        run_frame(1'b1, 32'h0000_0010, 32'($urandom), 3);
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (rb[k] !== e[8*(k-5) +: 8] || rv[k] !== 1'b1) begin
                errors++;
                $display("FAIL spurious_read c%0d: got byte=%h rv=%b, want byte=%h rv=1",
                         k, rb[k], rv[k], e[8*(k-5) +: 8]);
            end
        end
        checks++;
        if (fd[8] !== 1'b1 || bz[9] !== 1'b0) begin
            errors++;
            $display("FAIL spurious_end: got done=%b busy_c9=%b, want done=1 busy_c9=0", fd[8], bz[9]);
        end
        run_frame(1'b1, 32'h0000_0013, 32'h0, -1);
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (rb[k] !== e[8*(k-5) +: 8]) begin
                errors++;
                $display("FAIL low_bits_ignored c%0d: got %h, want %h", k, rb[k], e[8*(k-5) +: 8]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e;
        e = 32'h0BAD_F00D;
        run_frame(1'b0, 32'h0000_0008, e, -1);
        bus.frame_sync = 1'b1; bus.rw = 1'b0; bus.addr_byte = 8'h08; bus.wdata_byte = 8'h55;
        @(posedge clk); #1;
        bus.frame_sync = 1'b0; bus.addr_byte = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 3; c <= 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.rdata_byte, bus.rdata_valid, bus.busy, bus.frame_done, bus.range_err} !== 12'h0) begin
                errors++;
                $display("FAIL midrst_outputs c%0d: got rbyte=%h rv=%b busy=%b done=%b rerr=%b, want all 0",
                         c, bus.rdata_byte, bus.rdata_valid, bus.busy, bus.frame_done, bus.range_err);
            end
        end
        rst = 1'b0;
        run_frame(1'b1, 32'h0000_0008, 32'h0, -1);
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (rb[k] !== e[8*(k-5) +: 8] || rv[k] !== 1'b1 || re[k] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_old_value c%0d: got byte=%h rv=%b rerr=%b, want byte=%h rv=1 rerr=0",
                         k, rb[k], rv[k], re[k], e[8*(k-5) +: 8]);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.frame_sync = 1'b0;
        bus.rw         = 1'b0;
        bus.addr_byte  = 8'h00;
        bus.wdata_byte = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_range();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
